// File: rtl/decode_queue_pkg.sv
// decode_pkg: shared opcode values, class encodings and the decoded payload
// type for the ARM32 decode queue.
//   - OP_* : 7-bit internal opcodes produced by instr_field_decode
//   - PFX_*: upper opcode bits selecting the ALU operand form
//   - decoded_t: one FIFO payload entry (the PC is stored alongside it)
//   - alu_sub(): maps instr[24:21] to {legal, 3-bit ALU sub-opcode}
package decode_pkg;

  localparam logic [6:0] OP_NOP     = 7'b0000000;
  localparam logic [6:0] OP_HALT    = 7'b0000001;
  localparam logic [6:0] OP_UNDEF   = 7'b0000001;
  localparam logic [6:0] OP_B       = 7'b1000000;
  localparam logic [6:0] OP_BL      = 7'b1000100;
  localparam logic [6:0] OP_BX      = 7'b1000001;
  localparam logic [6:0] OP_BLX     = 7'b1000101;
  localparam logic [6:0] OP_MOV_IMM = 7'b0000000;
  localparam logic [6:0] OP_MOV_REG = 7'b0010000;
  localparam logic [6:0] OP_MOV_RSH = 7'b0110000;

  // Operand-form prefixes for ALU ops: immediate, register, shifted register
  localparam logic [3:0] PFX_ALU_IMM = 4'b0001;
  localparam logic [3:0] PFX_ALU_REG = 4'b0011;
  localparam logic [3:0] PFX_ALU_RSH = 4'b0111;
  localparam logic [2:0] PFX_LDST    = 3'b101;

  // instr[27:21] patterns for special class-00 encodings
  localparam logic [6:0] ENC_NOP  = 7'b0011001;
  localparam logic [6:0] ENC_HALT = 7'b0001000;
  localparam logic [6:0] ENC_BX   = 7'b0001001;

  localparam logic [3:0] DP_ADD = 4'b0100;
  localparam logic [3:0] DP_SUB = 4'b0010;
  localparam logic [3:0] DP_CMP = 4'b1010;
  localparam logic [3:0] DP_AND = 4'b0000;
  localparam logic [3:0] DP_ORR = 4'b1100;
  localparam logic [3:0] DP_EOR = 4'b0001;
  localparam logic [3:0] DP_MOV = 4'b1101;

  typedef struct packed {
    logic [3:0]  cond;
    logic [6:0]  opcode;
    logic        en_status;
    logic [3:0]  rn;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [3:0]  rm;
    logic [1:0]  shift_op;
    logic [4:0]  imm5;
    logic [11:0] imm12;
    logic [23:0] imm24;
    logic        illegal;
  } decoded_t;

  // MOV is not handled here; it has its own fixed opcodes per operand form.
  function automatic logic [3:0] alu_sub(input logic [3:0] dp);
    case (dp)
      DP_ADD:  return 4'b1_000;
      DP_SUB:  return 4'b1_001;
      DP_CMP:  return 4'b1_010;
      DP_AND:  return 4'b1_011;
      DP_ORR:  return 4'b1_100;
      DP_EOR:  return 4'b1_101;
      default: return 4'b0_000;
    endcase
  endfunction

endpackage

// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-side and execute-side handshake bundle of the
// decode queue, plus flush and occupancy.
//   slave  modport: the queue (consumes in_*, flush, out_ready)
//   master modport: the environment driving fetch/execute
interface decode_queue_if #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) ();

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_instr;
  logic [PC_W-1:0]   in_pc;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [3:0]        out_cond;
  logic [6:0]        out_opcode;
  logic              out_en_status;
  logic [3:0]        out_rn;
  logic [3:0]        out_rd;
  logic [3:0]        out_rs;
  logic [3:0]        out_rm;
  logic [1:0]        out_shift_op;
  logic [4:0]        out_imm5;
  logic [11:0]       out_imm12;
  logic [23:0]       out_imm24;
  logic              out_illegal;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_pc, out_cond, out_opcode, out_en_status,
           out_rn, out_rd, out_rs, out_rm, out_shift_op, out_imm5,
           out_imm12, out_imm24, out_illegal, count
  );

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_pc, out_cond, out_opcode, out_en_status,
           out_rn, out_rd, out_rs, out_rm, out_shift_op, out_imm5,
           out_imm12, out_imm24, out_illegal, count
  );

endinterface

// File: rtl/decode_queue_instr_field_decode.sv
// instr_field_decode: combinational ARM32 field extraction and opcode
// classification.
//   instr : raw 32-bit instruction
//   dec   : decoded_t bundle (raw fields always extracted)
// Optional macro LDST_DECODE_EN: decode class 01 as load/store instead of
// flagging it illegal.
module instr_field_decode
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  output decoded_t    dec
);

  logic [3:0] alu_res;
  logic [3:0] alu_pfx;
  logic [6:0] mov_op;

  assign alu_res = alu_sub(instr[24:21]);
  assign alu_pfx = instr[25] ? PFX_ALU_IMM : (instr[4] ? PFX_ALU_RSH : PFX_ALU_REG);
  assign mov_op  = instr[25] ? OP_MOV_IMM : (instr[4] ? OP_MOV_RSH : OP_MOV_REG);

  always_comb begin
    dec           = '0;
    dec.cond      = instr[31:28];
    dec.en_status = instr[20];
    dec.rn        = instr[19:16];
    dec.rd        = instr[15:12];
    dec.rs        = instr[11:8];
    dec.rm        = instr[3:0];
    dec.shift_op  = instr[7:6];
    dec.imm5      = instr[11:7];
    dec.imm12     = instr[11:0];
    dec.imm24     = instr[23:0];
    dec.opcode    = OP_UNDEF;
    dec.illegal   = 1'b1;

    case (instr[27:26])
      2'b00: begin
        // Special encodings take priority over the generic ALU decode.
        if (instr[27:21] == ENC_NOP) begin
          dec.opcode  = OP_NOP;
          dec.illegal = 1'b0;
        end else if (instr[27:21] == ENC_HALT) begin
          dec.opcode  = OP_HALT;
          dec.illegal = 1'b0;
        end else if (instr[27:21] == ENC_BX) begin
          dec.opcode  = instr[5] ? OP_BLX : OP_BX;
          dec.illegal = 1'b0;
        end else if (instr[24:21] == DP_MOV) begin
          dec.opcode  = mov_op;
          dec.illegal = 1'b0;
        end else if (alu_res[3]) begin
          dec.opcode  = {alu_pfx, alu_res[2:0]};
          dec.illegal = 1'b0;
        end
      end
      2'b01: begin
`ifdef LDST_DECODE_EN
        dec.opcode  = {PFX_LDST, instr[24], instr[23], instr[22], instr[20]};
        dec.illegal = 1'b0;
`endif
      end
      2'b10: begin
        if (instr[25]) begin
          dec.opcode  = instr[24] ? OP_BL : OP_B;
          dec.illegal = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decode_queue.sv
// decode_queue: registered, buffered decode stage between fetch and execute.
// Instructions are decoded on enqueue and held with their PC in a DEPTH-entry
// FIFO, presented in order through a valid/ready handshake.
//   clk, rst : clock, asynchronous active-high reset
//   q        : decode_queue_if.slave (flush, in_* fetch side, out_* execute
//              side, count occupancy)
// Parameters: DEPTH (power of two, 2..16), PC_W.
// Optional macro LDST_DECODE_EN (see instr_field_decode).
module decode_queue
  import decode_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PC_W  = 32
) (
  input  logic           clk,
  input  logic           rst,
  decode_queue_if.slave  q
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  decoded_t         dec_in;
  decoded_t         dec_mem [DEPTH];
  logic [PC_W-1:0]  pc_mem  [DEPTH];
  decoded_t         head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  instr_field_decode u_decode (
    .instr (q.in_instr),
    .dec   (dec_in)
  );

  // Ready depends on stored occupancy only, so a full queue refuses a push
  // even when the head is popped in the same cycle.
  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);
  assign push  = q.in_valid & ~full;
  assign pop   = q.out_ready & ~empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        dec_mem[i] <= '0;
        pc_mem[i]  <= '0;
      end
    end else if (q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        dec_mem[wr_ptr] <= dec_in;
        pc_mem[wr_ptr]  <= q.in_pc;
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: ;
      endcase
    end
  end

  assign head            = dec_mem[rd_ptr];
  assign q.in_ready      = ~full;
  assign q.out_valid     = ~empty;
  assign q.count         = cnt;
  assign q.out_pc        = pc_mem[rd_ptr];
  assign q.out_cond      = head.cond;
  assign q.out_opcode    = head.opcode;
  assign q.out_en_status = head.en_status;
  assign q.out_rn        = head.rn;
  assign q.out_rd        = head.rd;
  assign q.out_rs        = head.rs;
  assign q.out_rm        = head.rm;
  assign q.out_shift_op  = head.shift_op;
  assign q.out_imm5      = head.imm5;
  assign q.out_imm12     = head.imm12;
  assign q.out_imm24     = head.imm24;
  assign q.out_illegal   = head.illegal;

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Registered, buffered instruction-decode stage for the ARM32 core, placed between the fetch stage and the issue/execute stage.
- Each accepted 32-bit instruction is decoded when it is enqueued. The decoded bundle and its fetch PC are held in a DEPTH-entry FIFO.
- Entries are presented in order to execute through a valid/ready handshake.
- Adds buffering, back-pressure, pipeline flush and explicit illegal-instruction flagging to plain field decode.

Parameters:
- DEPTH, 4: FIFO entries; power of two, 2..16.
- PC_W, 32: width of the PC tag carried with each instruction.

Ports:
- clk  in  1  sole clock; rising edge.
- rst  in  1  reset; asynchronous, active-high.
- flush  in  1  discard all queued entries (branch redirect).
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  queue can accept an instruction.
- in_instr  in  32  raw instruction.
- in_pc  in  PC_W  PC of in_instr.
- out_valid  out  1  head entry valid.
- out_ready  in  1  execute consumes the head entry.
- out_pc  out  PC_W  PC of the head entry.
- out_cond  out  4  head entry field, bits [31:28].
- out_opcode  out  7  head entry internal opcode.
- out_en_status  out  1  head entry field, bit [20].
- out_rn  out  4  head entry field, bits [19:16].
- out_rd  out  4  head entry field, bits [15:12].
- out_rs  out  4  head entry field, bits [11:8].
- out_rm  out  4  head entry field, bits [3:0].
- out_shift_op  out  2  head entry field, bits [7:6].
- out_imm5  out  5  head entry field, bits [11:7].
- out_imm12  out  12  head entry field, bits [11:0].
- out_imm24  out  24  head entry field, bits [23:0].
- out_illegal  out  1  head entry is an undefined encoding.
- count  out  $clog2(DEPTH+1)  number of occupied entries.

Behaviour:
- Reset (asynchronous, active-high):
  - Pointers and count cleared.
  - All storage and all out_* fields read 0.
  - out_valid=0, in_ready=1.
- Handshake and timing:
  - Push when in_valid & in_ready. Pop when out_valid & out_ready.
  - in_ready = (count != DEPTH); it is registered-state-only, with no combinational path from out_ready.
  - out_valid = (count != 0).
  - An entry pushed in cycle N is visible at the outputs in cycle N+1, so latency is 1.
  - out_* are stable while out_valid=1 and out_ready=0.
- Boundary conditions:
  - Simultaneous push and pop with 0 < count < DEPTH: count is unchanged and both pointers advance.
  - When full, a push is refused even if a pop occurs in the same cycle.
  - Pointers wrap modulo DEPTH.
- flush:
  - Synchronous. The next cycle has count=0 and out_valid=0.
  - flush overrides a same-cycle push and pop; the pushed instruction is dropped.
- Decode rules, opcode names per the package:
  - Class [27:26]=00:
    - [27:21]=0011001 → NOP 0000000.
    - [27:21]=0001000 → HALT 0000001, with illegal=0.
    - [27:21]=0001001 → BX 1000001 if bit5=0, else BLX 1000101.
    - Otherwise the ALU op comes from [24:21]: ADD 0100→000, SUB 0010→001, CMP 1010→010, AND 0000→011, ORR 1100→100, EOR 0001→101, MOV 1101→MOV.
    - Prefix when I=bit25 is set: 0001xxx; immediate MOV = 0000000.
    - Prefix when I=0 and bit4=0: 0011xxx; register MOV = 0010000.
    - Prefix when I=0 and bit4=1: 0111xxx; shifted-register MOV = 0110000.
    - Any other ALU op → illegal.
  - Class [27:25]=101: bit24=0 → B 1000000; bit24=1 → BL 1000100.
  - Class 100, class 11 and class 01 (without the optional feature) → illegal.
- Any illegal encoding gives opcode=0000001 and illegal=1.
- Raw fields are always extracted regardless of class.

Optional Feature:
- Macro: LDST_DECODE_EN.
- Defined: class 01 decodes as load/store with opcode = {3'b101, instr[24], instr[23], instr[22], instr[20]} (P, U, B, L) and illegal=0.
- Undefined: class 01 is illegal (opcode 0000001, illegal=1).

Decomposition:
- Package decode_pkg:
  - localparams for every opcode value and the class prefixes.
  - A packed struct decoded_t holding cond, opcode, en_status, rn, rd, rs, rm, shift_op, imm5, imm12, imm24, illegal, which is the FIFO entry payload alongside the PC.
- Sub-module instr_field_decode: purely combinational, mapping a 32-bit instruction to decoded_t.
- decode_queue instantiates instr_field_decode at its input and owns the FIFO, handshake and flush logic.

Test Plan:
- Reset mid-stream with count=3: assert rst → out_valid=0, count=0, in_ready=1, out_opcode=0 immediately.
- Push E3A01005 (MOV r1,#5), pc=0x100 → next cycle out_valid=1, opcode=0000000, rd=1, imm12=0x005, cond=E, out_pc=0x100.
- Push in sequence:
  - E0821003 → 0011000, rn=2, rd=1, rm=3.
  - EAFFFFFE → 1000000, imm24=FFFFFE.
  - E12FFF1E → 1000001, rm=E.
  - FFFFFFFF → 0000001, illegal=1.
  - Pop in order and check each result.
- DEPTH=4, out_ready=0, push 5 instructions → in_ready drops after the 4th, count=4. The 5th is held by fetch and accepted one cycle after the first pop.
- count=2, flush asserted together with a push and a pop → next cycle count=0, out_valid=0, and no entry from that cycle survives.
- E5912000 (LDR r2,[r1]): with LDST_DECODE_EN → opcode 1011101, illegal=0. Without it → 0000001, illegal=1.
